div_rep_sub: RTL and testbench

DIV_REP_SUB -- requirements
Module: div_rep_sub

---
 rtl/div_rep_sub_pkg.sv | 16 +
 rtl/div_datapath.sv | 53 +++++
 rtl/div_rep_sub.sv | 85 ++++++++
 tb/tb_div_rep_sub.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/div_rep_sub_pkg.sv
// Shared definitions for the repeated-subtraction divider: FSM state
// encoding and the default operand width.
package div_rep_sub_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CHECK  = 3'd3,
        SUB    = 3'd4,
        DONE   = 3'd5
    } div_state_e;

endpackage

// File: rtl/div_datapath.sv
// Divider datapath: dividend/remainder (A), divisor (B) and quotient (Q)
// registers, plus the subtractor, incrementer and status compares.
module div_datapath
    import div_rep_sub_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             clr_q,
    input  logic             sub_a,
    input  logic             inc_q,
    output logic             a_ge_b,
    output logic             b_eqz,
    output logic [WIDTH-1:0] a_val,
    output logic [WIDTH-1:0] q_val
);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] q_reg;

    // sub_a is only issued after a_ge_b was seen, so A - B cannot wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            q_reg <= '0;
        end else begin
            if (ld_a)
                a_reg <= data_in;
            else if (sub_a)
                a_reg <= a_reg - b_reg;

            if (ld_b)
                b_reg <= data_in;

            if (clr_q)
                q_reg <= '0;
            else if (inc_q)
                q_reg <= q_reg + WIDTH'(1);
        end
    end

    assign a_ge_b = (a_reg >= b_reg);
    assign b_eqz  = (b_reg == '0);
    assign a_val  = a_reg;
    assign q_val  = q_reg;

endmodule

// File: rtl/div_rep_sub.sv
// Unsigned divider by repeated subtraction. Dividend then divisor arrive on
// a shared bus; done stays high in DONE until start is released.
module div_rep_sub
    import div_rep_sub_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             div_zero
);

    div_state_e state;
    logic       a_ge_b;
    logic       b_eqz;

    div_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .ld_a    (state == LOAD_A),
        .ld_b    (state == LOAD_B),
        .clr_q   (state == LOAD_A),
        .sub_a   (state == SUB),
        .inc_q   (state == SUB),
        .a_ge_b  (a_ge_b),
        .b_eqz   (b_eqz),
        .a_val   (remainder),
        .q_val   (quotient)
    );

    // Each CHECK/SUB round trip costs two cycles, giving latency 3 + 2*Q
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start)
                        state <= LOAD_A;
                end
                LOAD_A: begin
                    div_zero <= 1'b0;
                    state    <= LOAD_B;
                end
                LOAD_B: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (b_eqz) begin
                        div_zero <= 1'b1;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (a_ge_b) begin
                        state <= SUB;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                SUB: begin
                    state <= CHECK;
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_rep_sub.sv
// Scoreboard bench for div_rep_sub: directed and random divisions checked
// against plain integer division, including latency and reset abort.
module tb_div_rep_sub;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        done;
    logic        div_zero;

    logic        start8;
    logic [7:0]  data8;
    logic [7:0]  q8;
    logic [7:0]  r8;
    logic        done8;
    logic        dz8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_done = 1'b0;

    typedef struct {
        int q;
        int r;
        int dz;
        int lat;
        int k;
    } exp_t;

    exp_t sb_q[$];

    div_rep_sub #(.WIDTH(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data_in   (data_in),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .div_zero  (div_zero)
    );

    div_rep_sub #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .data_in   (data8),
        .quotient  (q8),
        .remainder (r8),
        .done      (done8),
        .div_zero  (dz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every rising edge of done is matched against the oldest expectation
    always @(negedge clk) begin
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("quotient", int'(quotient), e.q);
                check("remainder", int'(remainder), e.r);
                check("div_zero", int'(div_zero), e.dz);
                check("latency", cyc - e.k, e.lat);
            end
        end
        prev_done <= done;
    end

    task automatic run_op(input int dvd, input int dvs, input bit hold);
        exp_t e;
        int n;
        if (dvs == 0) begin
            e.q = 0; e.r = dvd; e.dz = 1;
        end else begin
            e.q = dvd / dvs; e.r = dvd % dvs; e.dz = 0;
        end
        e.lat = (dvs == 0) ? 3 : 3 + 2 * e.q;
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'(dvd);
        @(negedge clk);
        e.k = cyc;
        if (!hold) start = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        data_in = 16'(dvs);
        n = 0;
        while (done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            check("done_timeout", 0, 1);
            void'(sb_q.pop_front());
            return;
        end
        if (hold) begin
            repeat (3) @(negedge clk);
            check("done_held", int'(done), 1);
            start = 1'b0;
        end
        @(negedge clk);
        check("done_fall", int'(done), 0);
        repeat (2) @(negedge clk);
        check("idle_quotient", int'(quotient), e.q);
        check("idle_remainder", int'(remainder), e.r);
    endtask

    initial begin
        int dvd;
        int dvs;
        int lo;
        int n;
        int k8;
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        start8  = 1'b0;
        data8   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_done", int'(done), 0);
        check("rst_div_zero", int'(div_zero), 0);

        run_op(17, 10, 1'b0);
        run_op(100, 7, 1'b0);
        run_op(5, 9, 1'b0);
        run_op(42, 0, 1'b0);
        run_op(9, 9, 1'b0);
        run_op(0, 0, 1'b0);
        run_op(0, 5, 1'b0);
        run_op(65535, 65535, 1'b0);
        run_op(65535, 300, 1'b0);
        run_op(1000, 3, 1'b1);

        for (int i = 0; i < 16; i++) begin
            dvd = int'($urandom_range(0, 65535));
            lo  = dvd / 300 + 1;
            dvs = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(lo, lo + 500));
            run_op(dvd, dvs, i[0]);
        end

        // Abort 100/7 mid-computation with reset, then confirm a clean restart
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd100;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        data_in = 16'd7;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_quotient", int'(quotient), 0);
        check("abort_remainder", int'(remainder), 0);
        check("abort_done", int'(done), 0);
        check("abort_div_zero", int'(div_zero), 0);
        repeat (40) @(negedge clk);
        check("abort_no_resume", int'(done), 0);
        run_op(17, 10, 1'b0);

        // Maximum quotient on the narrow instance: 255 / 1
        @(negedge clk);
        start8 = 1'b1;
        data8  = 8'd255;
        @(negedge clk);
        k8     = cyc;
        start8 = 1'b0;
        @(negedge clk);
        data8 = 8'd1;
        n = 0;
        while (done8 !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("max_q_done", int'(done8), 1);
        check("max_q_latency", cyc - k8, 3 + 2 * 255);
        check("max_q_quotient", int'(q8), 255);
        check("max_q_remainder", int'(r8), 0);
        check("max_q_div_zero", int'(dz8), 0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
